// File: rtl/wave_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : wave_cmd_decoder
// Brief    : Parses 1-3 byte command frames from the SPI client byte stream
//            and maintains the wave generator configuration registers
//            (wave select, 16-bit phase increment, 8-bit amplitude).
//            Multi-byte values commit atomically once the frame is complete;
//            a stalled partial frame is dropped by an inter-byte timeout.
//            Optional feature macro: CMD_CHECKSUM_EN (adds a trailing XOR
//            checksum byte to every non-NOP frame, checked in a CHK state).
// Revision : 1.0 - initial release
// ============================================================================
module wave_cmd_decoder #(
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter logic [1:0]  RESET_WAVE     = 2'd0,
    parameter logic [15:0] RESET_FREQ     = 16'd0,
    parameter logic [7:0]  RESET_AMP      = 8'hFF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  command,
    input  logic        command_signal,
    output logic [1:0]  wave_sel,
    output logic [15:0] freq_word,
    output logic [7:0]  amplitude,
    output logic        cfg_update,
    output logic        frame_err,
    output logic        frame_active
);

    localparam int unsigned     c_TW   = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [c_TW-1:0] c_TMAX = c_TW'(TIMEOUT_CYCLES);
    localparam logic [c_TW-1:0] c_ONE  = c_TW'(1);

    localparam logic [2:0] c_ST_IDLE    = 3'd0;
    localparam logic [2:0] c_ST_FREQ_HI = 3'd1;
    localparam logic [2:0] c_ST_FREQ_LO = 3'd2;
    localparam logic [2:0] c_ST_AMP     = 3'd3;
`ifdef CMD_CHECKSUM_EN
    localparam logic [2:0] c_ST_CHK     = 3'd4;
`endif

    localparam logic [1:0] c_OP_WAVE = 2'b01;
    localparam logic [1:0] c_OP_FREQ = 2'b10;
    localparam logic [1:0] c_OP_AMP  = 2'b11;

    logic [2:0]      r_state,  w_state_nxt;
    logic [7:0]      r_hi,     w_hi_nxt;
    logic [c_TW-1:0] r_timer,  w_timer_nxt;
    logic [1:0]      r_wave,   w_wave_nxt;
    logic [15:0]     r_freq,   w_freq_nxt;
    logic [7:0]      r_amp,    w_amp_nxt;
    logic            r_upd,    w_upd_nxt;
    logic            r_err,    w_err_nxt;
    logic            r_active;
    logic            w_timeout;
`ifdef CMD_CHECKSUM_EN
    logic [1:0]      r_op,     w_op_nxt;
    logic [7:0]      r_chk,    w_chk_nxt;
    logic [7:0]      r_lo,     w_lo_nxt;
`endif

    // A frame in progress is aborted only when no byte arrives in the limit cycle
    assign w_timeout = (r_state != c_ST_IDLE) && !command_signal && (r_timer == c_TMAX);

    // Next-state, staging and commit decisions
    always_comb begin
        w_state_nxt = r_state;
        w_hi_nxt    = r_hi;
        w_wave_nxt  = r_wave;
        w_freq_nxt  = r_freq;
        w_amp_nxt   = r_amp;
        w_upd_nxt   = 1'b0;
        w_err_nxt   = 1'b0;
`ifdef CMD_CHECKSUM_EN
        w_op_nxt    = r_op;
        w_chk_nxt   = r_chk;
        w_lo_nxt    = r_lo;
`endif
        if (w_timeout) begin
            w_state_nxt = c_ST_IDLE;
            w_err_nxt   = 1'b1;
        end else if (command_signal) begin
            case (r_state)
                c_ST_IDLE: begin
`ifdef CMD_CHECKSUM_EN
                    w_op_nxt  = command[7:6];
                    w_chk_nxt = command;
                    w_lo_nxt  = {6'd0, command[1:0]};
                    case (command[7:6])
                        c_OP_WAVE: w_state_nxt = c_ST_CHK;
                        c_OP_FREQ: w_state_nxt = c_ST_FREQ_HI;
                        c_OP_AMP:  w_state_nxt = c_ST_AMP;
                        default:   w_state_nxt = c_ST_IDLE;
                    endcase
`else
                    case (command[7:6])
                        c_OP_WAVE: begin
                            w_wave_nxt = command[1:0];
                            w_upd_nxt  = 1'b1;
                        end
                        c_OP_FREQ: w_state_nxt = c_ST_FREQ_HI;
                        c_OP_AMP:  w_state_nxt = c_ST_AMP;
                        default:   w_state_nxt = c_ST_IDLE;
                    endcase
`endif
                end
                c_ST_FREQ_HI: begin
                    w_hi_nxt    = command;
                    w_state_nxt = c_ST_FREQ_LO;
`ifdef CMD_CHECKSUM_EN
                    w_chk_nxt   = r_chk ^ command;
`endif
                end
                c_ST_FREQ_LO: begin
`ifdef CMD_CHECKSUM_EN
                    w_lo_nxt    = command;
                    w_chk_nxt   = r_chk ^ command;
                    w_state_nxt = c_ST_CHK;
`else
                    w_freq_nxt  = {r_hi, command};
                    w_upd_nxt   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
`endif
                end
                c_ST_AMP: begin
`ifdef CMD_CHECKSUM_EN
                    w_lo_nxt    = command;
                    w_chk_nxt   = r_chk ^ command;
                    w_state_nxt = c_ST_CHK;
`else
                    w_amp_nxt   = command;
                    w_upd_nxt   = 1'b1;
                    w_state_nxt = c_ST_IDLE;
`endif
                end
`ifdef CMD_CHECKSUM_EN
                c_ST_CHK: begin
                    w_state_nxt = c_ST_IDLE;
                    if (command == r_chk) begin
                        w_upd_nxt = 1'b1;
                        case (r_op)
                            c_OP_WAVE: w_wave_nxt = r_lo[1:0];
                            c_OP_FREQ: w_freq_nxt = {r_hi, r_lo};
                            c_OP_AMP:  w_amp_nxt  = r_lo;
                            default:   w_upd_nxt  = 1'b0;
                        endcase
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
`endif
                default: w_state_nxt = c_ST_IDLE;
            endcase
        end
    end

    // Inter-byte timer: cleared by any byte or while idle, saturates at the limit
    always_comb begin
        w_timer_nxt = r_timer;
        if ((r_state == c_ST_IDLE) || command_signal || w_timeout) begin
            w_timer_nxt = '0;
        end else if (r_timer != c_TMAX) begin
            w_timer_nxt = r_timer + c_ONE;
        end
    end

    // State, staging, timer and configuration registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= c_ST_IDLE;
            r_hi     <= '0;
            r_timer  <= '0;
            r_wave   <= RESET_WAVE;
            r_freq   <= RESET_FREQ;
            r_amp    <= RESET_AMP;
            r_upd    <= 1'b0;
            r_err    <= 1'b0;
            r_active <= 1'b0;
`ifdef CMD_CHECKSUM_EN
            r_op     <= '0;
            r_chk    <= '0;
            r_lo     <= '0;
`endif
        end else begin
            r_state  <= w_state_nxt;
            r_hi     <= w_hi_nxt;
            r_timer  <= w_timer_nxt;
            r_wave   <= w_wave_nxt;
            r_freq   <= w_freq_nxt;
            r_amp    <= w_amp_nxt;
            r_upd    <= w_upd_nxt;
            r_err    <= w_err_nxt;
            r_active <= (w_state_nxt != c_ST_IDLE);
`ifdef CMD_CHECKSUM_EN
            r_op     <= w_op_nxt;
            r_chk    <= w_chk_nxt;
            r_lo     <= w_lo_nxt;
`endif
        end
    end

    assign wave_sel     = r_wave;
    assign freq_word    = r_freq;
    assign amplitude    = r_amp;
    assign cfg_update   = r_upd;
    assign frame_err    = r_err;
    assign frame_active = r_active;

endmodule
`default_nettype wire

// File: tb/tb_wave_cmd_decoder.sv
`default_nettype none
// ============================================================================
// Module   : tb_wave_cmd_decoder
// Brief    : Directed and randomized stimulus for wave_cmd_decoder, compared
//            every cycle against a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_wave_cmd_decoder;

    localparam int c_T = 40;
`ifdef CMD_CHECKSUM_EN
    localparam int c_EXTRA = 1;
`else
    localparam int c_EXTRA = 0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  command = 8'h00;
    logic        command_signal = 1'b0;
    logic [1:0]  wave_sel;
    logic [15:0] freq_word;
    logic [7:0]  amplitude;
    logic        cfg_update;
    logic        frame_err;
    logic        frame_active;

    wave_cmd_decoder #(
        .TIMEOUT_CYCLES (c_T),
        .RESET_WAVE     (2'd0),
        .RESET_FREQ     (16'd0),
        .RESET_AMP      (8'hFF)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .command        (command),
        .command_signal (command_signal),
        .wave_sel       (wave_sel),
        .freq_word      (freq_word),
        .amplitude      (amplitude),
        .cfg_update     (cfg_update),
        .frame_err      (frame_err),
        .frame_active   (frame_active)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: a frame is a list of bytes of known total length
    logic [1:0]  m_wave;
    logic [15:0] m_freq;
    logic [7:0]  m_amp;
    logic        m_upd, m_err;
    logic [7:0]  m_buf [4];
    int          m_len, m_need, m_gap;

    function automatic int frame_len(input logic [7:0] op);
        case (op[7:6])
            2'b00:   return 1;
            2'b01:   return 1 + c_EXTRA;
            2'b10:   return 3 + c_EXTRA;
            default: return 2 + c_EXTRA;
        endcase
    endfunction

    task automatic finish_frame();
        logic [7:0] x;
        logic [1:0] op;
        op = m_buf[0][7:6];
        x  = 8'h00;
        for (int i = 0; i < m_need - 1; i++) x ^= m_buf[i];
        if (c_EXTRA != 0 && op != 2'b00 && x != m_buf[m_need-1]) begin
            m_err = 1'b1;
        end else if (op == 2'b01) begin
            m_wave = m_buf[0][1:0]; m_upd = 1'b1;
        end else if (op == 2'b10) begin
            m_freq = {m_buf[1], m_buf[2]}; m_upd = 1'b1;
        end else if (op == 2'b11) begin
            m_amp = m_buf[1]; m_upd = 1'b1;
        end
        m_need = 0;
    endtask

    task automatic model(input logic s, input logic [7:0] b, input logic r);
        if (r) begin
            m_wave = 2'd0; m_freq = 16'd0; m_amp = 8'hFF;
            m_upd = 1'b0; m_err = 1'b0; m_need = 0; m_len = 0; m_gap = 0;
            return;
        end
        m_upd = 1'b0;
        m_err = 1'b0;
        if (s) begin
            if (m_need == 0) begin
                m_need = frame_len(b);
                m_len  = 0;
            end
            m_buf[m_len] = b;
            m_len++;
            m_gap = 0;
            if (m_len == m_need) finish_frame();
        end else if (m_need != 0) begin
            m_gap++;
            if (m_gap > c_T) begin
                m_err  = 1'b1;
                m_need = 0;
            end
        end
    endtask

    task automatic check_one(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_all();
        check_one("wave_sel",     {14'd0, wave_sel},     {14'd0, m_wave});
        check_one("freq_word",    freq_word,             m_freq);
        check_one("amplitude",    {8'd0, amplitude},     {8'd0, m_amp});
        check_one("cfg_update",   {15'd0, cfg_update},   {15'd0, m_upd});
        check_one("frame_err",    {15'd0, frame_err},    {15'd0, m_err});
        check_one("frame_active", {15'd0, frame_active}, {15'd0, (m_need != 0)});
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare
    task automatic step(input logic s, input logic [7:0] b, input logic r);
        command_signal = s;
        command        = b;
        rst            = r;
        @(posedge clk);
        model(s, b, r);
        #1;
        check_all();
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [7:0] rb;
        int         gap;
        // Reset, then quiet period
        step(1'b0, 8'h00, 1'b1);
        step(1'b0, 8'h00, 1'b1);
        idle(100);
        // Three-byte frequency frame
        send(8'h80); send(8'h12); send(8'h34);
        idle(3);
        // Wave select followed immediately by amplitude frame
        send(8'h42); send(8'hC0); send(8'h7F);
        idle(3);
        // Frequency frame stalls; timeout aborts it, then wave select works
        send(8'h80); send(8'hAB);
        idle(c_T + 3);
        send(8'h41);
        idle(2);
        // Byte arriving exactly on the limit cycle keeps the frame alive
        send(8'hC0);
        idle(c_T);
        send(8'h5A);
        idle(2);
        // Reset in the middle of a frame
        send(8'h80); send(8'hAB);
        step(1'b0, 8'h00, 1'b1);
        send(8'hCD); send(8'hEF);
        idle(3);
        // Unchanged value still pulses cfg_update
        send(8'h41); send(8'h41);
        idle(2);
`ifdef CMD_CHECKSUM_EN
        send(8'hC0); send(8'h55); send(8'h95);
        idle(2);
        send(8'hC0); send(8'h55); send(8'h00);
        idle(2);
`endif
        // Randomized byte stream with mixed gaps and occasional resets
        for (int k = 0; k < 2500; k++) begin
            rb = 8'($urandom);
            if ($urandom_range(0, 99) < 2) begin
                step(1'b0, 8'h00, 1'b1);
            end else begin
                send(rb);
            end
            case ($urandom_range(0, 19))
                0:       gap = c_T - 1;
                1:       gap = c_T;
                2:       gap = c_T + 1;
                3:       gap = c_T + 2;
                default: gap = int'($urandom_range(0, 3));
            endcase
            idle(gap);
        end
        idle(c_T + 5);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
